fir_ctrl_sequencer: RTL and testbench

Control sequencer that sits directly upstream of the reconfigurable FIR filter and generates all of its control and data inputs from the 12 MHz domain. It buffers host-supplied coefficients and bursts them into the filter's four coefficient banks, ten per bank. On every 600 kHz sample strobe it presents the new 3-bit input sample and runs the 10-cycle memory-read/MAC sweep for the selected module. It guarantees that coefficient-write bursts and read sweeps never overlap on the filter's shared control lines.

---
 rtl/fir_ctrl_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_fir_ctrl_sequencer.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_ctrl_sequencer.sv
// Drives the reconfigurable FIR from the 12 MHz domain. Host coefficients are staged in a FIFO and
// written as bursts to four banks. Each sample strobe triggers one memory-read/MAC sweep.
//
// state | meaning
// IDLE  | nothing driven; a pending sample is served first, then a full bank of staged coefficients
// RD    | TAPS-cycle memory-read/MAC sweep for the captured module and sample
// WR    | TAPS-cycle coefficient burst into the current bank, popping the FIFO each cycle
module fir_ctrl_sequencer #(
    parameter int TAPS       = 10,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk_12m_i,
    input  logic        rst_i,
    input  logic        en_sample_600k_i,
    input  logic [2:0]  fir_in_i,
    input  logic [1:0]  rd_sel_i,
    input  logic        coeff_wr_valid_i,
    input  logic [15:0] coeff_wr_data_i,
    output logic        coeff_wr_ready_o,
    output logic        coeff_update_flag_o,
    output logic [15:0] wt_dt_ram_o,
    output logic        mem_rd_flag_o,
    output logic [1:0]  module_sel_o,
    output logic [2:0]  fir_in_o,
    output logic        coeff_loaded_o,
    output logic        overrun_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int TAP_W = (TAPS > 1) ? $clog2(TAPS) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [TAP_W-1:0] cnt_q, cnt_d;
    logic [1:0]       bank_q, bank_d;
    logic             pend_q, pend_d;
    logic             pend_consume;
    logic [2:0]       cap_fir_q, cap_fir_d;
    logic [1:0]       cap_sel_q, cap_sel_d;

    logic [15:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;

    logic             ready_q, ready_d;
    logic             upd_q, upd_d;
    logic [15:0]      wt_q, wt_d;
    logic             mem_rd_q, mem_rd_d;
    logic [1:0]       sel_q, sel_d;
    logic [2:0]       fir_q, fir_d;
    logic             loaded_q, loaded_d;
    logic             overrun_q, overrun_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bank_d       = bank_q;
        loaded_d     = loaded_q;
        pend_consume = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pend_q) begin
                    state_d      = ST_RD;
                    cnt_d        = '0;
                    pend_consume = 1'b1;
                end else if (count_q >= CNT_W'(TAPS)) begin
                    state_d = ST_WR;
                    cnt_d   = '0;
                end
            end
            ST_RD: begin
                if (cnt_q == TAP_W'(TAPS - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WR: begin
                if (cnt_q == TAP_W'(TAPS - 1)) begin
                    state_d = ST_IDLE;
                    bank_d  = bank_q + 2'd1;
                    if (bank_q == 2'd3) begin
                        loaded_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // A strobe in the same cycle the previous one is consumed is a fresh request, not a loss.
    always_comb begin
        pend_d    = pend_q;
        cap_fir_d = cap_fir_q;
        cap_sel_d = cap_sel_q;
        overrun_d = overrun_q;
        if (pend_consume) begin
            pend_d = 1'b0;
        end
        if (en_sample_600k_i) begin
            pend_d    = 1'b1;
            cap_fir_d = fir_in_i;
            cap_sel_d = rd_sel_i;
            if (pend_q && !pend_consume) begin
                overrun_d = 1'b1;
            end
        end
    end

    assign push = coeff_wr_valid_i && ready_q;
    assign pop  = (state_d == ST_WR);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        ready_d = (count_d < CNT_W'(FIFO_DEPTH));
    end

    // Outputs are registered from the next state so they line up with the state they belong to.
    always_comb begin
        mem_rd_d = 1'b0;
        upd_d    = 1'b0;
        wt_d     = '0;
        sel_d    = '0;
        fir_d    = '0;
        case (state_d)
            ST_RD: begin
                mem_rd_d = 1'b1;
                if (state_q != ST_RD) begin
                    sel_d = cap_sel_q;
                    fir_d = cap_fir_q;
                end else begin
                    sel_d = sel_q;
                end
            end
            ST_WR: begin
                upd_d = 1'b1;
                sel_d = bank_q;
                wt_d  = fifo_mem[rd_ptr_q];
            end
            default: begin
                sel_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_12m_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= coeff_wr_data_i;
        end
    end

    always_ff @(posedge clk_12m_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bank_q    <= '0;
            pend_q    <= 1'b0;
            cap_fir_q <= '0;
            cap_sel_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ready_q   <= 1'b1;
            upd_q     <= 1'b0;
            wt_q      <= '0;
            mem_rd_q  <= 1'b0;
            sel_q     <= '0;
            fir_q     <= '0;
            loaded_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bank_q    <= bank_d;
            pend_q    <= pend_d;
            cap_fir_q <= cap_fir_d;
            cap_sel_q <= cap_sel_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ready_q   <= ready_d;
            upd_q     <= upd_d;
            wt_q      <= wt_d;
            mem_rd_q  <= mem_rd_d;
            sel_q     <= sel_d;
            fir_q     <= fir_d;
            loaded_q  <= loaded_d;
            overrun_q <= overrun_d;
        end
    end

    assign coeff_wr_ready_o    = ready_q;
    assign coeff_update_flag_o = upd_q;
    assign wt_dt_ram_o         = wt_q;
    assign mem_rd_flag_o       = mem_rd_q;
    assign module_sel_o        = sel_q;
    assign fir_in_o            = fir_q;
    assign coeff_loaded_o      = loaded_q;
    assign overrun_o           = overrun_q;

endmodule

// File: tb/tb_fir_ctrl_sequencer.sv
// Bench for fir_ctrl_sequencer: expected burst words and sweeps are queued as stimulus is driven
// and popped as the filter-side outputs appear.
module tb_fir_ctrl_sequencer;

    localparam int TAPS = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [2:0]  fir_in = '0;
    logic [1:0]  rd_sel = '0;
    logic        valid = 1'b0;
    logic [15:0] data = '0;
    logic        coeff_wr_ready;
    logic        coeff_update_flag;
    logic [15:0] wt_dt_ram;
    logic        mem_rd_flag;
    logic [1:0]  module_sel;
    logic [2:0]  fir_out;
    logic        coeff_loaded;
    logic        overrun;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [17:0] wr_q[$];
    logic [4:0]  rd_q[$];
    int          tb_words = 0;
    int          upd_len = 0;
    int          rd_len = 0;
    logic [1:0]  cur_sel = '0;

    fir_ctrl_sequencer #(.TAPS(TAPS), .FIFO_DEPTH(16)) dut (
        .clk_12m_i          (clk),
        .rst_i              (rst),
        .en_sample_600k_i   (en),
        .fir_in_i           (fir_in),
        .rd_sel_i           (rd_sel),
        .coeff_wr_valid_i   (valid),
        .coeff_wr_data_i    (data),
        .coeff_wr_ready_o   (coeff_wr_ready),
        .coeff_update_flag_o(coeff_update_flag),
        .wt_dt_ram_o        (wt_dt_ram),
        .mem_rd_flag_o      (mem_rd_flag),
        .module_sel_o       (module_sel),
        .fir_in_o           (fir_out),
        .coeff_loaded_o     (coeff_loaded),
        .overrun_o          (overrun)
    );

    always #42 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

    // One clock, then scoreboard the filter-side outputs.
    task automatic cycle();
        logic [17:0] ew;
        logic [4:0]  er;
        @(posedge clk);
        #1;
        n_checks++;
        if ((mem_rd_flag & coeff_update_flag) !== 1'b0) begin
            n_fail++;
            $display("FAIL flag_overlap: mem_rd=%b upd=%b, required not both 1", mem_rd_flag, coeff_update_flag);
        end
        if (coeff_update_flag === 1'b1) begin
            n_checks++;
            if (wr_q.size() == 0) begin
                n_fail++;
                $display("FAIL wr_unexpected: sel=%0d word=%h, required no burst", module_sel, wt_dt_ram);
            end else begin
                ew = wr_q.pop_front();
                if ({module_sel, wt_dt_ram, fir_out} !== {ew, 3'b000}) begin
                    n_fail++;
                    $display("FAIL wr_word: sel/word/fir=%0d/%h/%0d, required %0d/%h/0",
                             module_sel, wt_dt_ram, fir_out, ew[17:16], ew[15:0]);
                end
            end
            upd_len++;
        end else if (upd_len != 0) begin
            n_checks++;
            if (upd_len != TAPS) begin
                n_fail++;
                $display("FAIL wr_length: %0d cycles, required %0d", upd_len, TAPS);
            end
            upd_len = 0;
        end
        if (mem_rd_flag === 1'b1) begin
            n_checks++;
            if (rd_len == 0) begin
                if (rd_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rd_unexpected: sel=%0d fir=%0d, required no sweep", module_sel, fir_out);
                end else begin
                    er = rd_q.pop_front();
                    cur_sel = er[4:3];
                    if ({module_sel, fir_out, wt_dt_ram} !== {er, 16'h0}) begin
                        n_fail++;
                        $display("FAIL rd_first: sel/fir/word=%0d/%0d/%h, required %0d/%0d/0",
                                 module_sel, fir_out, wt_dt_ram, er[4:3], er[2:0]);
                    end
                end
            end else if ({module_sel, fir_out, wt_dt_ram} !== {cur_sel, 3'b000, 16'h0}) begin
                n_fail++;
                $display("FAIL rd_hold: sel/fir/word=%0d/%0d/%h, required %0d/0/0",
                         module_sel, fir_out, wt_dt_ram, cur_sel);
            end
            rd_len++;
        end else if (rd_len != 0) begin
            n_checks++;
            if (rd_len != TAPS) begin
                n_fail++;
                $display("FAIL rd_length: %0d cycles, required %0d", rd_len, TAPS);
            end
            rd_len = 0;
        end
        if (mem_rd_flag !== 1'b1 && coeff_update_flag !== 1'b1) begin
            n_checks++;
            if ({module_sel, fir_out, wt_dt_ram} !== 21'h0) begin
                n_fail++;
                $display("FAIL idle_outputs: sel/fir/word=%0d/%0d/%h, required 0/0/0", module_sel, fir_out, wt_dt_ram);
            end
        end
    endtask

    task automatic push_word(input logic [15:0] d);
        int n = 0;
        while (coeff_wr_ready !== 1'b1 && n < 50) begin
            cycle();
            n++;
        end
        n_checks++;
        if (n >= 50) begin
            n_fail++;
            $display("FAIL ready_timeout: ready=%b, required 1 within 50 cycles", coeff_wr_ready);
        end
        valid = 1'b1;
        data  = d;
        wr_q.push_back({2'((tb_words / TAPS) % 4), d});
        tb_words++;
        cycle();
        valid = 1'b0;
    endtask

    task automatic strobe(input logic [2:0] f, input logic [1:0] s, input bit expect_rd);
        en     = 1'b1;
        fir_in = f;
        rd_sel = s;
        if (expect_rd) rd_q.push_back({s, f});
        cycle();
        en     = 1'b0;
        fir_in = '0;
        rd_sel = '0;
    endtask

    task automatic wait_quiet();
        int n = 0;
        while ((wr_q.size() != 0 || rd_q.size() != 0 || mem_rd_flag !== 1'b0 || coeff_update_flag !== 1'b0) && n < 300) begin
            cycle();
            n++;
        end
        n_checks++;
        if (n >= 300) begin
            n_fail++;
            $display("FAIL quiet_timeout: wr_q=%0d rd_q=%0d left, required 0 within 300 cycles", wr_q.size(), rd_q.size());
        end
        cycle();
    endtask

    task automatic wait_upd();
        int n = 0;
        while (coeff_update_flag !== 1'b1 && n < 50) begin
            cycle();
            n++;
        end
        n_checks++;
        if (n >= 50) begin
            n_fail++;
            $display("FAIL upd_timeout: upd=%b, required 1 within 50 cycles", coeff_update_flag);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        n_checks++;
        if ({coeff_wr_ready, coeff_update_flag, mem_rd_flag, module_sel, wt_dt_ram, fir_out, coeff_loaded, overrun}
            !== {1'b1, 25'h0}) begin
            n_fail++;
            $display("FAIL reset_values: ready=%b upd=%b rd=%b sel=%0d word=%h fir=%0d loaded=%b ovr=%b, required ready=1 rest 0",
                     coeff_wr_ready, coeff_update_flag, mem_rd_flag, module_sel, wt_dt_ram, fir_out, coeff_loaded, overrun);
        end
        for (int i = 0; i < 20; i++) begin
            cycle();
            n_checks++;
            if ({mem_rd_flag, coeff_update_flag} !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_quiet: rd=%b upd=%b at cycle %0d, required 00", mem_rd_flag, coeff_update_flag, i);
            end
        end
    endtask

    task automatic test_full_load();
        for (int i = 0; i < 40; i++) begin
            push_word(16'h0a00 + 16'((i / 10) * 256 + (i % 10)));
        end
        n_checks++;
        if (coeff_loaded !== 1'b0) begin
            n_fail++;
            $display("FAIL loaded_early: loaded=%b, required 0 before bank 3 burst", coeff_loaded);
        end
        wait_quiet();
        n_checks++;
        if ({coeff_loaded, overrun} !== 2'b10) begin
            n_fail++;
            $display("FAIL loaded_after: loaded=%b ovr=%b, required 1/0", coeff_loaded, overrun);
        end
    endtask

    task automatic test_single_sample();
        strobe(3'b001, 2'b01, 1'b1);
        cycle();
        n_checks++;
        if ({mem_rd_flag, module_sel, fir_out} !== {1'b1, 2'b01, 3'b001}) begin
            n_fail++;
            $display("FAIL sample1_first: rd=%b sel=%0d fir=%0d, required 1/1/1", mem_rd_flag, module_sel, fir_out);
        end
        for (int k = 1; k < TAPS; k++) cycle();
        n_checks++;
        if ({mem_rd_flag, fir_out} !== {1'b1, 3'b000}) begin
            n_fail++;
            $display("FAIL sample1_last: rd=%b fir=%0d, required 1/0", mem_rd_flag, fir_out);
        end
        cycle();
        n_checks++;
        if (mem_rd_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL sample1_end: rd=%b, required 0", mem_rd_flag);
        end
        for (int k = 0; k < 8; k++) cycle();
        strobe(3'b000, 2'b01, 1'b1);
        cycle();
        n_checks++;
        if ({mem_rd_flag, module_sel, fir_out} !== {1'b1, 2'b01, 3'b000}) begin
            n_fail++;
            $display("FAIL sample2_first: rd=%b sel=%0d fir=%0d, required 1/1/0", mem_rd_flag, module_sel, fir_out);
        end
        wait_quiet();
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL sample_overrun: ovr=%b, required 0", overrun);
        end
    endtask

    task automatic test_collision();
        for (int i = 0; i < 9; i++) push_word(16'h1100 + 16'(i));
        valid = 1'b1;
        data  = 16'h1109;
        wr_q.push_back({2'((tb_words / TAPS) % 4), 16'h1109});
        tb_words++;
        strobe(3'b101, 2'b10, 1'b1);
        valid = 1'b0;
        cycle();
        n_checks++;
        if ({mem_rd_flag, coeff_update_flag} !== 2'b10) begin
            n_fail++;
            $display("FAIL collision_rd_first: rd=%b upd=%b, required 1/0", mem_rd_flag, coeff_update_flag);
        end
        for (int k = 1; k < TAPS; k++) cycle();
        cycle();
        n_checks++;
        if ({mem_rd_flag, coeff_update_flag} !== 2'b00) begin
            n_fail++;
            $display("FAIL collision_gap: rd=%b upd=%b, required 0/0", mem_rd_flag, coeff_update_flag);
        end
        cycle();
        n_checks++;
        if ({coeff_update_flag, module_sel, wt_dt_ram} !== {1'b1, 2'b00, 16'h1100}) begin
            n_fail++;
            $display("FAIL collision_wr: upd=%b sel=%0d word=%h, required 1/0/1100", coeff_update_flag, module_sel, wt_dt_ram);
        end
        wait_quiet();
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 10; i++) push_word(16'h2200 + 16'(i));
        wait_upd();
        cycle();
        cycle();
        strobe(3'b010, 2'b11, 1'b0);
        cycle();
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_early: ovr=%b, required 0 after one strobe", overrun);
        end
        strobe(3'b110, 2'b10, 1'b1);
        n_checks++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_set: ovr=%b, required 1", overrun);
        end
        wait_quiet();
        n_checks++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_sticky: ovr=%b, required 1", overrun);
        end
    endtask

    task automatic test_reset_mid_burst();
        for (int i = 0; i < 10; i++) push_word(16'h3300 + 16'(i));
        wait_upd();
        cycle();
        cycle();
        cycle();
        wr_q.delete();
        rd_q.delete();
        upd_len  = 0;
        rd_len   = 0;
        tb_words = 0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        n_checks++;
        if ({coeff_update_flag, coeff_wr_ready, coeff_loaded, overrun, module_sel} !== 6'b010000) begin
            n_fail++;
            $display("FAIL midrst_outputs: upd=%b ready=%b loaded=%b ovr=%b sel=%0d, required 0/1/0/0/0",
                     coeff_update_flag, coeff_wr_ready, coeff_loaded, overrun, module_sel);
        end
        for (int i = 0; i < 9; i++) push_word(16'h0e00 + 16'(i));
        cycle();
        cycle();
        cycle();
        n_checks++;
        if (coeff_update_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_flushed: upd=%b with 9 words, required 0", coeff_update_flag);
        end
        push_word(16'h0e09);
        cycle();
        n_checks++;
        if ({coeff_update_flag, module_sel, wt_dt_ram} !== {1'b1, 2'b00, 16'h0e00}) begin
            n_fail++;
            $display("FAIL midrst_bank0: upd=%b sel=%0d word=%h, required 1/0/0e00", coeff_update_flag, module_sel, wt_dt_ram);
        end
        wait_quiet();
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_single_sample();
        test_collision();
        test_overrun();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
